// File: rtl/hazard_stall_unit_pkg.sv
// Shared decode constants for the hazard stall unit: MIPS opcodes/functs and the
// helpers that turn an opcode into the ID-stage hazard controls.
package hazard_stall_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [OP_W-1:0] FUNCT_SUB = 6'h22;

  // rt is a source for R-type, compare-in-ID branches and stores
  function automatic logic dec_uses_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic dec_mem_read(input logic [OP_W-1:0] op);
    return (op == OP_LW);
  endfunction

  function automatic logic dec_branch(input logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic dec_reg_write(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/hazard_shadow_regs.sv
// Shadow copy of the EX and MEM stage destination info, tracking the real
// ID/EX and EX/MEM registers including inserted bubbles.
module hazard_shadow_regs
  import hazard_stall_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble_i,
  input  logic [REG_W-1:0] id_wr_i,
  input  logic             id_memread_i,
  input  logic             id_regwrite_i,
  output logic [REG_W-1:0] ex_rd_o,
  output logic             ex_memread_o,
  output logic             ex_regwrite_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             mem_memread_o
);

  logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q;
  logic             ex_memread_q, ex_memread_d, mem_memread_q;
  logic             ex_regwrite_q, ex_regwrite_d;

  // A stalled ID instruction does not advance; EX receives a nop instead
  always_comb begin
    ex_rd_d       = id_wr_i;
    ex_memread_d  = id_memread_i;
    ex_regwrite_d = id_regwrite_i;
    if (bubble_i) begin
      ex_rd_d       = REG_ZERO;
      ex_memread_d  = 1'b0;
      ex_regwrite_d = 1'b0;
    end
  end

  // Only MEM-stage loads can still block an ID-stage branch, so only the
  // load flag and destination are carried into MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd_q       <= REG_ZERO;
      ex_memread_q  <= 1'b0;
      ex_regwrite_q <= 1'b0;
      mem_rd_q      <= REG_ZERO;
      mem_memread_q <= 1'b0;
    end else begin
      ex_rd_q       <= ex_rd_d;
      ex_memread_q  <= ex_memread_d;
      ex_regwrite_q <= ex_regwrite_d;
      mem_rd_q      <= ex_rd_q;
      mem_memread_q <= ex_memread_q;
    end
  end

  assign ex_rd_o       = ex_rd_q;
  assign ex_memread_o  = ex_memread_q;
  assign ex_regwrite_o = ex_regwrite_q;
  assign mem_rd_o      = mem_rd_q;
  assign mem_memread_o = mem_memread_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: detects load-use and branch-operand hazards that
// forwarding cannot cover, drives pipeline enables and counts stall cycles.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_MemRead,
  input  logic             ID_RegWrite,
  input  logic [REG_W-1:0] ID_WriteReg,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_W-1:0] ex_rd, mem_rd;
  logic             ex_memread, ex_regwrite, mem_memread;
  logic             ld_use, br_haz, stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_shadow_regs u_shadow (
    .clk          (clk),
    .rst          (rst),
    .bubble_i     (stall),
    .id_wr_i      (ID_WriteReg),
    .id_memread_i (ID_MemRead),
    .id_regwrite_i(ID_RegWrite),
    .ex_rd_o      (ex_rd),
    .ex_memread_o (ex_memread),
    .ex_regwrite_o(ex_regwrite),
    .mem_rd_o     (mem_rd),
    .mem_memread_o(mem_memread)
  );

  // Register 0 is hardwired and never creates a dependency
  function automatic logic src_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    ld_use = ex_memread && src_match(ex_rd, IF_ID_Rs, IF_ID_Rt, ID_uses_Rt);
    br_haz = ID_Branch &&
             ((ex_regwrite && src_match(ex_rd, IF_ID_Rs, IF_ID_Rt, ID_uses_Rt)) ||
              (mem_memread && src_match(mem_rd, IF_ID_Rs, IF_ID_Rt, ID_uses_Rt)));
    stall  = ld_use || br_haz;
  end

  // A stalled branch sees stale operands, so its flush waits for re-evaluation
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    if (!rst) begin
      if (stall) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else begin
        IF_ID_Flush  = ID_Branch && ID_BranchTaken;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: instruction-level vector table plus reset and
// counter-saturation sequences, checked through an expected-result queue.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_WriteReg;
  logic       ID_uses_Rt, ID_Branch, ID_BranchTaken, ID_MemRead, ID_RegWrite;

  logic        pcw_a, ifw_a, bub_a, fl_a;
  logic [15:0] cnt_a;
  logic        pcw_b, ifw_b, bub_b, fl_b;
  logic [1:0]  cnt_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [4:0]  rs, rt, wr;
    logic        taken;
    logic        pcw, ifw, bub, flush;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_uses_Rt(ID_uses_Rt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
    .ID_MemRead(ID_MemRead), .ID_RegWrite(ID_RegWrite), .ID_WriteReg(ID_WriteReg),
    .PCWrite(pcw_a), .IF_ID_Write(ifw_a), .ID_EX_Bubble(bub_a),
    .IF_ID_Flush(fl_a), .stall_cnt(cnt_a)
  );

  hazard_stall_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_uses_Rt(ID_uses_Rt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
    .ID_MemRead(ID_MemRead), .ID_RegWrite(ID_RegWrite), .ID_WriteReg(ID_WriteReg),
    .PCWrite(pcw_b), .IF_ID_Write(ifw_b), .ID_EX_Bubble(bub_b),
    .IF_ID_Flush(fl_b), .stall_cnt(cnt_b)
  );

  // Expected outputs follow from whether this cycle stalls / flushes and the
  // number of stalls seen since reset; reset forces the idle pattern
  task automatic add_vec(input string nm, input logic r, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic tk, input logic st, input logic fl, input int unsigned c);
    vec_t v;
    v.name = nm; v.rst = r; v.op = op; v.rs = rs; v.rt = rt; v.wr = wr; v.taken = tk;
    v.pcw   = r | ~st;
    v.ifw   = r | ~st;
    v.bub   = ~r & st;
    v.flush = ~r & fl;
    v.cnt   = r ? 0 : c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    IF_ID_Rs       = v.rs;
    IF_ID_Rt       = v.rt;
    ID_uses_Rt     = dec_uses_rt(v.op);
    ID_Branch      = dec_branch(v.op);
    ID_BranchTaken = v.taken;
    ID_MemRead     = dec_mem_read(v.op);
    ID_RegWrite    = dec_reg_write(v.op);
    ID_WriteReg    = v.wr;
    sb.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    int unsigned sat;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = sb.pop_front();
    sat = (e.cnt > 3) ? 3 : e.cnt;
    chk(e.name, "PCWrite",     32'(pcw_a), 32'(e.pcw));
    chk(e.name, "IF_ID_Write", 32'(ifw_a), 32'(e.ifw));
    chk(e.name, "ID_EX_Bubble",32'(bub_a), 32'(e.bub));
    chk(e.name, "IF_ID_Flush", 32'(fl_a),  32'(e.flush));
    chk(e.name, "stall_cnt",   32'(cnt_a), e.cnt);
    chk(e.name, "sat.PCWrite", 32'(pcw_b), 32'(e.pcw));
    chk(e.name, "sat.Flush",   32'(fl_b),  32'(e.flush));
    chk(e.name, "sat.Bubble",  32'(bub_b), 32'(e.bub));
    chk(e.name, "sat.IFIDW",   32'(ifw_b), 32'(e.ifw));
    chk(e.name, "sat.stall_cnt", 32'(cnt_b), sat);
  endtask

  initial begin
    rst = 1'b1;
    IF_ID_Rs = '0; IF_ID_Rt = '0; ID_WriteReg = '0;
    ID_uses_Rt = 1'b0; ID_Branch = 1'b0; ID_BranchTaken = 1'b0;
    ID_MemRead = 1'b0; ID_RegWrite = 1'b0;

    //      name            rst op        rs rt wr tk st fl cnt
    add_vec("reset0",       1, OP_RTYPE, 0, 0, 0, 0, 0, 0, 0);
    add_vec("reset1",       1, OP_RTYPE, 0, 0, 0, 0, 0, 0, 0);
    add_vec("t1_lw",        0, OP_LW,    1, 2, 2, 0, 0, 0, 0);
    add_vec("t1_add_stall", 0, OP_RTYPE, 2, 4, 3, 0, 1, 0, 0);
    add_vec("t1_add_go",    0, OP_RTYPE, 2, 4, 3, 0, 0, 0, 1);
    add_vec("t1_nop",       0, OP_RTYPE, 0, 0, 0, 0, 0, 0, 1);
    add_vec("t2_lw",        0, OP_LW,    1, 2, 2, 0, 0, 0, 1);
    add_vec("t2_beq_ld",    0, OP_BEQ,   2, 5, 0, 1, 1, 0, 1);
    add_vec("t2_beq_mem",   0, OP_BEQ,   2, 5, 0, 1, 1, 0, 2);
    add_vec("t2_beq_go",    0, OP_BEQ,   2, 5, 0, 1, 0, 1, 3);
    add_vec("t2_nop",       0, OP_RTYPE, 0, 0, 0, 0, 0, 0, 3);
    add_vec("t3_add",       0, OP_RTYPE, 1, 1, 2, 0, 0, 0, 3);
    add_vec("t3_beq_ex",    0, OP_BEQ,   2, 0, 0, 0, 1, 0, 3);
    add_vec("t3_beq_go",    0, OP_BEQ,   2, 0, 0, 0, 0, 0, 4);
    add_vec("t3_add2",      0, OP_RTYPE, 1, 1, 2, 0, 0, 0, 4);
    add_vec("t3_add_dep",   0, OP_RTYPE, 2, 2, 3, 0, 0, 0, 4);
    add_vec("t4_lw0",       0, OP_LW,    1, 0, 0, 0, 0, 0, 4);
    add_vec("t4_add_r0",    0, OP_RTYPE, 0, 0, 3, 0, 0, 0, 4);
    add_vec("t4_lw2",       0, OP_LW,    1, 2, 2, 0, 0, 0, 4);
    add_vec("t4_sw_stall",  0, OP_SW,    6, 2, 0, 0, 1, 0, 4);
    add_vec("t4_sw_go",     0, OP_SW,    6, 2, 0, 0, 0, 0, 5);
    add_vec("t4_lw5",       0, OP_LW,    1, 5, 5, 0, 0, 0, 5);
    add_vec("t4_addi_nort", 0, OP_ADDI,  7, 5, 5, 0, 0, 0, 5);
    add_vec("t5_beq_flush", 0, OP_BEQ,   1, 7, 0, 1, 0, 1, 5);
    add_vec("t5_nop",       0, OP_RTYPE, 0, 0, 0, 0, 0, 0, 5);
    add_vec("t5_add4",      0, OP_RTYPE, 1, 1, 4, 0, 0, 0, 5);
    add_vec("t5_beq_haz",   0, OP_BEQ,   4, 1, 0, 1, 1, 0, 5);
    add_vec("t5_beq_go",    0, OP_BEQ,   4, 1, 0, 1, 0, 1, 6);
    add_vec("t5_nop2",      0, OP_RTYPE, 0, 0, 0, 0, 0, 0, 6);

    // Reset asserted on the stall cycle of a load-use pair
    add_vec("t6_lw",        0, OP_LW,    1, 2, 2, 0, 0, 0, 6);
    add_vec("t6_add_rst",   1, OP_RTYPE, 2, 4, 3, 0, 1, 0, 6);
    add_vec("t6_add_after", 0, OP_RTYPE, 2, 4, 3, 0, 0, 0, 0);

    // Five load-use stalls: the 2-bit counter must stop at 3
    for (int k = 0; k < 5; k++) begin
      add_vec("sat_lw",     0, OP_LW,    1, 2, 2, 0, 0, 0, k);
      add_vec("sat_stall",  0, OP_RTYPE, 2, 4, 3, 0, 1, 0, k);
      add_vec("sat_go",     0, OP_RTYPE, 2, 4, 3, 0, 0, 0, k + 1);
    end
    add_vec("sat_final",    0, OP_RTYPE, 0, 0, 0, 0, 0, 0, 5);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check_out();
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
